// File: rtl/y_sig_misr.sv
// y_sig_misr: folds a 350-bit word stream into a 32-bit MISR signature over an N-cycle window,
// then holds it for a valid/ready handshake.
module y_sig_misr #(
    parameter int unsigned       SIG_W = 32,
    parameter logic [SIG_W-1:0]  POLY  = 32'h04C11DB7,
    parameter logic [SIG_W-1:0]  SEED  = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [349:0]     y,
    input  logic             start,
    input  logic [15:0]      num_cycles,
    input  logic             sig_ready,
    output logic             busy,
    output logic             sig_valid,
    output logic [SIG_W-1:0] sig,
    output logic [15:0]      cycle_cnt
);
    localparam int CHUNKS = (350 + SIG_W - 1) / SIG_W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [SIG_W-1:0]        sig_q, sig_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [15:0]             n_q, n_d;
    logic [CHUNKS*SIG_W-1:0] y_ext;
    logic [SIG_W-1:0]        fold;
    logic [SIG_W-1:0]        misr_step;

    assign y_ext     = (CHUNKS*SIG_W)'(y);
    assign misr_step = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;

    always_comb begin
        fold = '0;
        for (int k = 0; k < CHUNKS; k++) fold ^= y_ext[k*SIG_W +: SIG_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        case (state_q)
            IDLE: if (start) begin
                n_d     = num_cycles;
                sig_d   = SEED;
                cnt_d   = '0;
                state_d = (num_cycles != 16'd0) ? RUN : DONE;
            end
            RUN: begin
                sig_d = misr_step;
                cnt_d = cnt_q + 16'd1;
                // n_q is nonzero here, so n_q-1 cannot underflow
                if (cnt_q == n_q - 16'd1) state_d = DONE;
            end
            DONE: if (sig_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == RUN);
        sig_valid = (state_q == DONE);
    end

    assign sig       = sig_q;
    assign cycle_cnt = cnt_q;
endmodule

// File: tb/tb_y_sig_misr.sv
// tb_y_sig_misr: randomized windows checked against a GF(2) reference model of the signature.
module tb_y_sig_misr;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [349:0] y = '0;
    logic         start = 1'b0;
    logic [15:0]  num_cycles = '0;
    logic         sig_ready = 1'b0;
    logic         busy, sig_valid;
    logic [31:0]  sig;
    logic [15:0]  cycle_cnt;

    int          vecs = 0;
    int          errs = 0;
    logic [31:0] m_sig;
    int          m_cnt;

    y_sig_misr dut (
        .clk(clk), .rst_n(rst_n), .y(y), .start(start), .num_cycles(num_cycles),
        .sig_ready(sig_ready), .busy(busy), .sig_valid(sig_valid), .sig(sig), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [349:0] rand_y();
        logic [351:0] v;
        for (int i = 0; i < 11; i++) v[i*32 +: 32] = $urandom;
        return v[349:0];
    endfunction

    // every input bit lands on signature bit (index mod 32)
    function automatic logic [31:0] fold_of(input logic [349:0] v);
        logic [31:0] f = '0;
        for (int i = 0; i < 350; i++) f[i % 32] ^= v[i];
        return f;
    endfunction

    // multiply by x modulo the polynomial, then add the folded word
    function automatic logic [31:0] step(input logic [31:0] s, input logic [349:0] v);
        logic [32:0] p = {s, 1'b0};
        if (p[32]) p ^= {1'b1, POLY};
        return p[31:0] ^ fold_of(v);
    endfunction

    task automatic run_window(input int n, input bit rnd, input logic [349:0] fy);
        logic [349:0] w;
        m_sig = SEED;
        m_cnt = n;
        @(negedge clk);
        start = 1'b1;
        num_cycles = 16'(n);
        y = rand_y();
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (j == 0) chk("busy_run", {31'b0, busy}, 32'd1);
            start = 1'($urandom_range(0, 1));
            num_cycles = 16'($urandom);
            w = rnd ? rand_y() : fy;
            y = w;
            m_sig = step(m_sig, w);
        end
        @(negedge clk);
        start = 1'b0;
        chk("valid_done", {31'b0, sig_valid}, 32'd1);
        chk("busy_done", {31'b0, busy}, 32'd0);
        chk("sig_model", sig, m_sig);
        chk("cnt_done", {16'b0, cycle_cnt}, 32'(m_cnt));
    endtask

    task automatic hs();
        @(negedge clk);
        sig_ready = 1'b1;
        @(negedge clk);
        sig_ready = 1'b0;
        chk("valid_hs", {31'b0, sig_valid}, 32'd0);
        chk("busy_hs", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_sig", sig, SEED);
        chk("rst_cnt", {16'b0, cycle_cnt}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valid", {31'b0, sig_valid}, 32'd0);
        rst_n = 1'b1;

        run_window(1, 1'b0, '0);
        chk("y0_n1", sig, 32'hFB3EE249);
        hs();
        run_window(2, 1'b0, '0);
        chk("y0_n2", sig, 32'hF2BCD925);
        hs();
        run_window(1, 1'b0, (350'(1) << 32) | 350'(1));
        chk("fold_cancel", sig, 32'hFB3EE249);
        hs();
        run_window(1, 1'b0, 350'(1) << 349);
        chk("bit349", sig, 32'hDB3EE249);

        // long stall in DONE with start pulses, then handshake with start also high
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'(i % 2);
            chk("stall_sig", sig, m_sig);
            chk("stall_valid", {31'b0, sig_valid}, 32'd1);
        end
        @(negedge clk);
        sig_ready = 1'b1;
        start = 1'b1;
        num_cycles = 16'd4;
        @(negedge clk);
        sig_ready = 1'b0;
        start = 1'b0;
        chk("hs_valid", {31'b0, sig_valid}, 32'd0);
        chk("hs_start_ignored", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_sig_hold", sig, m_sig);
        chk("idle_cnt_hold", {16'b0, cycle_cnt}, 32'd1);

        run_window(0, 1'b1, '0);
        chk("n0_sig", sig, SEED);
        hs();

        // reset mid-window at cycle_cnt 3 of 10
        @(negedge clk);
        start = 1'b1;
        num_cycles = 16'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            y = rand_y();
            @(negedge clk);
        end
        chk("mid_cnt", {16'b0, cycle_cnt}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("arst_sig", sig, SEED);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_cnt", {16'b0, cycle_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_window(1, 1'b0, '0);
        chk("post_rst", sig, 32'hFB3EE249);
        hs();

        for (int t = 0; t < 6; t++) begin
            run_window(int'($urandom_range(1, 20)), 1'b1, '0);
            hs();
        end

        run_window(65535, 1'b1, '0);
        hs();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/y_sig_misr.md
Y_SIG_MISR -- requirements
Module: y_sig_misr

Interface
REQ-001 Parameter SIG_W, default 32, SHALL set the signature width (fixed at 32 in this release).
REQ-002 Parameter POLY, default 32'h04C11DB7, SHALL set the MISR feedback polynomial.
REQ-003 Parameter SEED, default 32'hFFFFFFFF, SHALL set the signature value loaded at reset and on each accepted start.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on posedge clk.
REQ-005 Port rst_n, input, 1 bit, SHALL be the reset; it is asynchronous and active-low.
REQ-006 Port y, input, 350 bits [349:0], SHALL carry the upstream stage's output word, sampled every RUN cycle.
REQ-007 Port start, input, 1 bit, SHALL request a new capture window.
REQ-008 Port num_cycles, input, 16 bits, SHALL give the window length N in cycles; it is sampled when start is accepted.
REQ-009 Port sig_ready, input, 1 bit, SHALL be the consumer's acceptance of the signature.
REQ-010 Port busy, output, 1 bit, SHALL be high while in RUN.
REQ-011 Port sig_valid, output, 1 bit, SHALL be high while in DONE.
REQ-012 Port sig, output, 32 bits, SHALL be the current MISR register.
REQ-013 Port cycle_cnt, output, 16 bits, SHALL be the number of y words folded so far in the current window.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the block SHALL latch N, set sig=SEED and cycle_cnt=0, and enter RUN if N!=0 or DONE if N=0.
REQ-016 Fold: y SHALL be zero-extended to 352 bits, split into eleven 32-bit chunks (chunk k = bits 32k+31..32k), and the chunks XORed to form fold[31:0].
REQ-017 On each RUN edge: sig <= {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold, and cycle_cnt <= cycle_cnt+1.
REQ-018 On the RUN edge where cycle_cnt==N-1, the state SHALL go to DONE; exactly N words are folded, on edges k+1..k+N after the start edge k.
REQ-019 In DONE, sig and cycle_cnt SHALL hold; sig_valid&&sig_ready SHALL move the state to IDLE on that edge.
REQ-020 start SHALL be ignored in RUN and DONE, including on the DONE->IDLE handshake edge; no queuing.
REQ-021 In IDLE with no start, sig and cycle_cnt SHALL hold their last values.
REQ-022 start and num_cycles changes during RUN SHALL NOT affect the active window.
REQ-023 N=16'hFFFF SHALL fold 65535 words with no counter wrap.

Reset
REQ-024 While rst_n=0, the block SHALL immediately force: state=IDLE, sig=SEED, cycle_cnt=0, busy=0, sig_valid=0, latched N=0.
REQ-025 Reset asserted mid-RUN or in DONE SHALL abort the window with no signature handshake.
REQ-026 After rst_n deasserts, the first start SHALL be accepted on the first clk edge.

Verification
REQ-027 y=0, N=1, start pulse -> after 2 edges sig_valid=1, sig=32'hFB3EE249, cycle_cnt=1.
REQ-028 y=0, N=2 -> sig=32'hF2BCD925; y=1<<0 together with 1<<32 (fold=0), N=1 -> sig=32'hFB3EE249; y=1<<349, N=1 -> sig=32'hDB3EE249.
REQ-029 N=0 -> DONE one edge after start, sig=SEED=32'hFFFFFFFF, cycle_cnt=0, busy never high.
REQ-030 Hold sig_ready=0 for 5 cycles in DONE and pulse start -> sig and sig_valid stable; sig_ready=1 -> IDLE next edge; start in the same cycle is ignored.
REQ-031 rst_n low for 1 cycle at cycle_cnt=3 of N=10 -> sig=SEED, busy=0 asynchronously; a new start with N=1, y=0 -> 32'hFB3EE249.
REQ-032 N=16'hFFFF with random y -> sig matches the reference model, cycle_cnt=16'hFFFF, sig_valid=1.
